// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory for the MEM stage: sub-word loads/stores, registered
// load response, alignment/range error strobe and a post-reset zero-fill sweep.
module data_mem_ctrl #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 128,
    parameter int ADDR_W    = 32,
    parameter int TEST_ADDR = 0,
    parameter int TEST_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              busy,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [TEST_W-1:0] test_value
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] TA = PTR_W'(TEST_ADDR);

    generate
        if ((DATA_W % 8) != 0 || DATA_W < 16 || DATA_W > 64 || TEST_W < 1 || TEST_W > DATA_W) begin : g_bad_params
            $error("data_mem_ctrl: illegal DATA_W or TEST_W");
        end
    endgenerate

    typedef enum logic {INIT, IDLE} state_t;

    state_t            state, state_nx;
    logic [PTR_W-1:0]  ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [PTR_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic [3:0]        nbytes;
    logic [2:0]        amask;
    logic              accept;
    logic              access_err;
    int unsigned       off_i, end_i, lim, sign_pos;
    logic [DATA_W-1:0] bit_en, wshift, rd_word, rshift, rext;
    logic              sign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT:    if (ptr == PTR_W'(DEPTH - 1)) state_nx = IDLE;
            IDLE:    state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               ptr <= '0;
        else if (state == INIT) ptr <= ptr + PTR_W'(1);
    end

    assign busy   = (state == INIT);
    assign ready  = (state == IDLE);
    assign accept = ready && req;

    assign word_idx   = addr >> OFF_W;
    assign idx        = word_idx[PTR_W-1:0];
    assign off        = addr[OFF_W-1:0];
    assign nbytes     = 4'd1 << size;
    assign amask      = 3'(nbytes - 4'd1);
    assign access_err = (int'(nbytes) > BYTES) || (|(addr[2:0] & amask))
                        || (word_idx >= ADDR_W'(DEPTH));

    assign off_i    = 32'(off);
    assign end_i    = off_i + 32'(nbytes);
    assign lim      = 32'd8 << size;
    assign sign_pos = ((lim < 32'(DATA_W)) ? lim : 32'(DATA_W)) - 32'd1;

    assign rd_word = mem[idx];
    assign wshift  = wdata << (off_i * 8);
    assign rshift  = rd_word >> (off_i * 8);

    always_comb begin
        bit_en = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (b >= off_i && b < end_i) bit_en[b*8 +: 8] = '1;
        end
    end

    // Extension source bit is found by loop so no variable-width bit index is needed.
    always_comb begin
        sign = 1'b0;
        rext = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i == sign_pos) sign = rshift[i];
        end
        for (int unsigned i = 0; i < DATA_W; i++) begin
            rext[i] = (i < lim) ? rshift[i] : (!uns && sign);
        end
    end

    // Array has no reset; the sweep is the only clearing mechanism.
    always_ff @(posedge clk) begin
        if (rst && busy)
            mem[ptr] <= '0;
        else if (accept && we && !access_err)
            mem[idx] <= (rd_word & ~bit_en) | (wshift & bit_en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            if (accept) begin
                err <= access_err;
                if (!we) begin
                    rvalid <= 1'b1;
                    rdata  <= access_err ? '0 : rext;
                end
            end
        end
    end

    assign test_value = busy ? '0 : mem[TA][TEST_W-1:0];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with default parameters.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'd0;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, busy, rvalid, err;
    logic [31:0] rdata;
    logic [15:0] test_value;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_ctrl #(
        .DATA_W(32),
        .DEPTH(128),
        .ADDR_W(32),
        .TEST_ADDR(0),
        .TEST_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .we(we),
        .size(size),
        .uns(uns),
        .addr(addr),
        .wdata(wdata),
        .ready(ready),
        .busy(busy),
        .rvalid(rvalid),
        .rdata(rdata),
        .err(err),
        .test_value(test_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents one request for the next posedge, returns at the following negedge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
        issue(1'b0, sz, u, a, '0);
        check({tag, "_rvalid"}, rvalid, 1);
        check({tag, "_err"}, err, exp_e);
        check({tag, "_rdata"}, rdata, exp_d);
    endtask

    task automatic store(input string tag, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input logic exp_e);
        issue(1'b1, sz, 1'b0, a, d);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_err"}, err, exp_e);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        #2;
        check({tag, "_ready"}, ready, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rdata"}, rdata, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Releases reset and counts edges until ready, while a store request is held to prove INIT ignores it.
    task automatic sweep(input string tag);
        int cyc = 0;
        bit tv_bad = 1'b0;
        bit strobe_bad = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h14; wdata = '1;
        while (!ready && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (test_value !== 16'h0) tv_bad = 1'b1;
            if (rvalid !== 1'b0 || err !== 1'b0) strobe_bad = 1'b1;
        end
        req = 1'b0;
        check({tag, "_cycles"}, cyc, 128);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tv_zero"}, tv_bad, 0);
        check({tag, "_no_strobe"}, strobe_bad, 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset("rst0");
        sweep("sweep0");

        // Non-zero content that the next sweep must clear
        store("st_dead", 2'd2, 32'h14, 32'hDEADBEEF, 0);
        load("ld_dead", 2'd2, 1'b0, 32'h14, 32'hDEADBEEF, 0);
        do_reset("rst1");
        sweep("sweep1");
        load("ld_swept", 2'd2, 1'b0, 32'h14, 32'h0, 0);

        store("st_word", 2'd2, 32'h00, 32'h12345678, 0);
        check("tv_after_store", test_value, 16'h5678);
        load("ld_word", 2'd2, 1'b0, 32'h00, 32'h12345678, 0);
        @(negedge clk);
        check("idle_rvalid", rvalid, 0);
        check("idle_err", err, 0);
        check("idle_rdata_hold", rdata, 32'h12345678);

        store("st_sub", 2'd2, 32'h08, 32'h80FF7F01, 0);
        load("ldb_s", 2'd0, 1'b0, 32'h0B, 32'hFFFFFF80, 0);
        load("ldb_u", 2'd0, 1'b1, 32'h0B, 32'h00000080, 0);
        load("ldb_pos", 2'd0, 1'b0, 32'h09, 32'h0000007F, 0);
        load("ldh_lo", 2'd1, 1'b0, 32'h08, 32'h00007F01, 0);
        load("ldh_hi", 2'd1, 1'b0, 32'h0A, 32'hFFFF80FF, 0);
        load("ldh_hi_u", 2'd1, 1'b1, 32'h0A, 32'h000080FF, 0);

        store("st_aa", 2'd2, 32'h10, 32'hAAAAAAAA, 0);
        store("st_b55", 2'd0, 32'h11, 32'hFFFFFF55, 0);
        load("ld_merge", 2'd2, 1'b0, 32'h10, 32'hAAAA55AA, 0);

        load("err_misal", 2'd1, 1'b0, 32'h03, 32'h0, 1);
        store("err_range", 2'd2, 32'h202, 32'hFFFFFFFF, 1);
        load("err_dword", 2'd3, 1'b0, 32'h00, 32'h0, 1);
        load("ld_intact", 2'd2, 1'b0, 32'h00, 32'h12345678, 0);
        store("st_b2b", 2'd2, 32'h04, 32'hCAFEF00D, 0);
        check("store_keeps_rdata", rdata, 32'h12345678);
        load("ld_b2b", 2'd2, 1'b0, 32'h04, 32'hCAFEF00D, 0);

        // Reset lands after the accept edge but before the response is sampled
        req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 1'b0;
        @(negedge clk);
        check("midrst_rvalid", rvalid, 0);
        check("midrst_err", err, 0);
        check("midrst_ready", ready, 0);
        @(negedge clk);
        sweep("sweep2");
        load("ld_after_midrst", 2'd2, 1'b0, 32'h00, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised successor to the single-cycle word data memory in the MiniMIPS MEM stage.
- Adds byte addressing, byte/half/word loads and stores with sign or zero extension, and a registered read with valid strobe.
- Flags misaligned and out-of-range accesses.
- Replaces the bulk async clear with a post-reset zero-fill sweep, during which the block reports not-ready.

Parameters:
DATA_W, 32, data word width in bits; multiple of 8, 16..64
DEPTH, 128, number of DATA_W words
ADDR_W, 32, byte-address width
TEST_ADDR, 0, word index exported on test_value
TEST_W, 16, width of test_value (<= DATA_W)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req  in  1  access request, qualified by ready
we  in  1  1 = store, 0 = load
size  in  2  access size = 2^size bytes (00 byte, 01 half, 10 word, 11 dword)
uns  in  1  load zero-extends when 1, sign-extends when 0
addr  in  ADDR_W  byte address
wdata  in  DATA_W  store data, right-justified
ready  out  1  block can accept req this cycle
busy  out  1  zero-fill sweep in progress
rvalid  out  1  one-cycle load-response strobe
rdata  out  DATA_W  load result, held until next load response
err  out  1  one-cycle error strobe for the accepted access
test_value  out  TEST_W  mem[TEST_ADDR][TEST_W-1:0]

Behaviour:
- Lanes are little-endian.
- OFF_W = log2(DATA_W/8).
- Word index = addr >> OFF_W; byte offset = addr[OFF_W-1:0].
- rst low (async):
  - ready=0, busy=1, rvalid=0, err=0, rdata=0.
  - State = INIT, sweep pointer = 0.
  - Memory array is not cleared by reset itself.
- State INIT:
  - Each cycle writes 0 to mem[ptr], then ptr++.
  - After the cycle writing DEPTH-1, go to IDLE.
  - ready=1 and busy=0 exactly DEPTH cycles after the first clk edge with rst high.
- In INIT, req is ignored: no write, no rvalid, no err.
- While busy=1, test_value is forced to 0.
- State IDLE: ready=1 permanently; accepts one access per cycle when req=1.
- Error check, evaluated at accept. The access is erroneous if any of these hold:
  - 2^size > DATA_W/8
  - addr not a multiple of 2^size
  - word index >= DEPTH
- Store, no error: write the 2^size low bytes of wdata into the addressed lanes at the accept edge. Other lanes are unchanged.
- Store with error: no write. err=1 in the next cycle; rvalid stays 0.
- Load, no error:
  - At the accept edge, capture the addressed lanes, extend per uns to DATA_W, and register into rdata.
  - rvalid=1 the next cycle (latency 1).
- Load with error: next cycle rvalid=1, err=1, rdata=0.
- rvalid and err are 0 in any cycle not following an accepted access that sets them.
- rdata holds its last value between load responses; stores do not alter it.
- Store at edge N followed by a load of the same address at edge N+1 returns the stored data (no forwarding hazard).
- test_value is combinational from the array once busy=0.
- Reset asserted mid-operation:
  - Any pending rvalid/err is dropped.
  - Sweep restarts from pointer 0.
  - A partially completed sweep is simply redone.
- Behaviour is unspecified if a parameter is outside its allowed range; elaboration asserts on illegal DATA_W or TEST_W.

Test Plan:
1. Reset/sweep (DEPTH=128): preload mem[5] with 0xDEADBEEF via hierarchy, pulse rst low, release.
   - ready=0 for exactly 128 cycles, then ready=1 and busy=0.
   - Load word 0x14 -> rvalid one cycle later, rdata=0x00000000.
   - test_value=0 throughout.
2. Word round trip: store 0x12345678 at 0x00, then load 0x00.
   - rvalid next cycle, rdata=0x12345678, err=0.
   - test_value=0x5678 from the cycle after the store.
3. Sub-word loads: store 0x80FF7F01 at 0x08.
   - Byte load 0x0B, uns=0 -> 0xFFFFFF80.
   - Byte load 0x0B, uns=1 -> 0x00000080.
   - Half load 0x08, uns=0 -> 0x00007F01.
   - Half load 0x0A, uns=0 -> 0xFFFF80FF.
4. Byte-enable store: word store 0xAAAAAAAA at 0x10, then byte store 0x55 at 0x11, then word load 0x10 -> 0xAAAA55AA.
5. Errors:
   - Half load at 0x03 -> rvalid=1, err=1, rdata=0.
   - Word store at 0x202 (index 128 >= DEPTH) -> err=1, rvalid=0, memory unchanged (readback of 0x00 intact).
   - size=11 with DATA_W=32 -> err=1.
6. Reset mid-operation: issue load, assert rst low on the following cycle before rvalid.
   - rvalid never asserts.
   - New 128-cycle sweep occurs.
   - Previously stored 0x12345678 at 0x00 reads back as 0.
